// File: rtl/shared_reg_pkg.sv
// shared_reg_pkg: FSM state and opcode encodings shared by the shared-register
// arbiter and its testbench.
// Contents: state_e (IDLE/GRANT/EXEC), OP_LOAD / OP_ACCUM opcode values.
package shared_reg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    EXEC  = 2'd2
  } state_e;

  localparam logic OP_LOAD  = 1'b0;
  localparam logic OP_ACCUM = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin winner select; search starts at ptr.
// Ports: req (request vector), ptr (first index to consider),
//        win_oh (one-hot winner), win_vld (any request present).
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int PW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] win_oh,
  output logic               win_vld
);

  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  // Walk NUM_REQ positions starting at ptr, wrapping modulo NUM_REQ;
  // the first asserted request wins.
  always_comb begin
    win_oh  = '0;
    win_vld = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      sum = {1'b0, ptr} + (PW+1)'(off);
      if (sum >= (PW+1)'(NUM_REQ)) begin
        sum = sum - (PW+1)'(NUM_REQ);
      end
      idx = sum[PW-1:0];
      if (!win_vld && req[idx]) begin
        win_oh[idx] = 1'b1;
        win_vld     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: sole writer of a shared WIDTH-bit register; requesters
// are served round-robin through IDLE -> GRANT -> EXEC -> IDLE (1 cycle each).
// Ports: clk, rst (sync, active-high), req/op/wdata per requester, ovf_clr;
//        gnt (one-hot, GRANT only), ack (EXEC only), reg_q, ovf (sticky), busy.
// Build option: define SHARED_REG_SAT_EN to make ACCUM saturate to all-ones
// instead of wrapping; ovf behaves the same either way.
module shared_reg_arbiter
  import shared_reg_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       op,
  input  logic [NUM_REQ*WIDTH-1:0] wdata,
  input  logic                     ovf_clr,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       ack,
  output logic [WIDTH-1:0]         reg_q,
  output logic                     ovf,
  output logic                     busy
);

  localparam int PW = $clog2(NUM_REQ);

  state_e               state_q;
  logic [PW-1:0]        ptr_q;
  logic [WIDTH-1:0]     data_q;
  logic                 ovf_q;
  logic [NUM_REQ-1:0]   gnt_q;
  logic [NUM_REQ-1:0]   ack_q;
  logic                 op_q;
  logic [WIDTH-1:0]     opnd_q;

  logic [NUM_REQ-1:0]   win_oh;
  logic                 win_vld;
  logic                 sel_op;
  logic [WIDTH-1:0]     sel_opnd;
  logic [PW-1:0]        ptr_d;
  logic [WIDTH:0]       acc_sum;
  logic [WIDTH-1:0]     acc_res;
  logic [WIDTH-1:0]     wr_dat_d;
  logic                 ovf_set_d;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req     (req),
    .ptr     (ptr_q),
    .win_oh  (win_oh),
    .win_vld (win_vld)
  );

  // Mux the winner's opcode/operand and the next round-robin start point.
  always_comb begin
    sel_op   = OP_LOAD;
    sel_opnd = '0;
    ptr_d    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_oh[i]) begin
        sel_op   = op[i];
        sel_opnd = wdata[i*WIDTH +: WIDTH];
        ptr_d    = (i == NUM_REQ-1) ? '0 : PW'(i+1);
      end
    end
  end

  // Accumulate one bit wider so the carry-out is visible as overflow.
  assign acc_sum = {1'b0, data_q} + {1'b0, opnd_q};

`ifdef SHARED_REG_SAT_EN
  assign acc_res = acc_sum[WIDTH] ? {WIDTH{1'b1}} : acc_sum[WIDTH-1:0];
`else
  assign acc_res = acc_sum[WIDTH-1:0];
`endif

  always_comb begin
    wr_dat_d  = opnd_q;
    ovf_set_d = 1'b0;
    if (op_q == OP_ACCUM) begin
      wr_dat_d  = acc_res;
      ovf_set_d = acc_sum[WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
      gnt_q   <= '0;
      ack_q   <= '0;
      op_q    <= OP_LOAD;
      opnd_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          ack_q <= '0;
          if (win_vld) begin
            // Operand is captured here, so a later req drop cannot cancel it.
            state_q <= GRANT;
            gnt_q   <= win_oh;
            op_q    <= sel_op;
            opnd_q  <= sel_opnd;
            ptr_q   <= ptr_d;
          end
        end
        GRANT: begin
          state_q <= EXEC;
          gnt_q   <= '0;
          ack_q   <= gnt_q;
          data_q  <= wr_dat_d;
        end
        EXEC: begin
          state_q <= IDLE;
          ack_q   <= '0;
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          ack_q   <= '0;
        end
      endcase
      // A set on the write edge takes priority over a concurrent clear.
      if (state_q == GRANT && ovf_set_d) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign gnt   = gnt_q;
  assign ack   = ack_q;
  assign reg_q = data_q;
  assign ovf   = ovf_q;
  assign busy  = (state_q != IDLE);

endmodule
